// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: seeds from the incoming stream, predicts each next sample,
// and reports lock/error status. Optional seven-segment display of err_cnt via LFSR_CHECKER_SEG_EN.

`ifdef LFSR_CHECKER_SEG_EN
module data2seg (
  input  logic [3:0] data_i,
  input  logic       neg_show_i,
  output logic [6:0] seg_o
);
  logic [6:0] pat;

  // pat is active-high gfedcba; the display segments are active-low
  always_comb begin
    pat = 7'h00;
    case (data_i)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      4'hF: pat = 7'h71;
      default: pat = 7'h00;
    endcase
    if (neg_show_i) pat = 7'h40;
  end

  assign seg_o = ~pat;
endmodule
`endif

// state | meaning
// IDLE  | waiting for a non-zero seed sample
// ACQ   | seeded, counting consecutive correct predictions
// LOCK  | locked; mispredictions counted, flywheel on predicted value
module lfsr_checker #(
  parameter int LOCK_CNT   = 4,
  parameter int ERR_THRESH = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        clr_cnt,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_cnt,
  output logic [13:0] hout
);
  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCK} state_t;

  localparam logic [3:0] LOCK_LAST = 4'(LOCK_CNT);
  localparam logic [3:0] ERR_LAST  = 4'(ERR_THRESH);

  state_t      state_q;
  logic [7:0]  prev_q;
  logic [3:0]  match_run_q;
  logic [3:0]  miss_run_q;
  logic        locked_q;
  logic        err_pulse_q;
  logic [15:0] err_cnt_q;

  logic [7:0]  exp_d;
  logic        hit_d;

  assign exp_d = {prev_q[4] ^ prev_q[3] ^ prev_q[2] ^ prev_q[0], prev_q[7:1]};
  assign hit_d = (in_data == exp_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      prev_q      <= '0;
      match_run_q <= '0;
      miss_run_q  <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      if (clr_cnt) err_cnt_q <= '0;
      if (in_valid) begin
        case (state_q)
          S_IDLE: begin
            if (in_data != 8'h00) begin
              prev_q      <= in_data;
              match_run_q <= '0;
              state_q     <= S_ACQ;
            end
          end
          S_ACQ: begin
            if (in_data == 8'h00) begin
              prev_q      <= '0;
              match_run_q <= '0;
              state_q     <= S_IDLE;
            end else begin
              prev_q <= in_data;
              if (hit_d) begin
                if (match_run_q + 4'd1 == LOCK_LAST) begin
                  state_q     <= S_LOCK;
                  locked_q    <= 1'b1;
                  match_run_q <= '0;
                  miss_run_q  <= '0;
                end else begin
                  match_run_q <= match_run_q + 4'd1;
                end
              end else begin
                match_run_q <= '0;
              end
            end
          end
          S_LOCK: begin
            if (hit_d) begin
              prev_q     <= in_data;
              miss_run_q <= '0;
            end else begin
              // keep predicting from the expected value so one bad sample does not derail tracking
              prev_q      <= exp_d;
              err_pulse_q <= 1'b1;
              if (!clr_cnt && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
              if (miss_run_q + 4'd1 == ERR_LAST) begin
                state_q     <= S_IDLE;
                locked_q    <= 1'b0;
                match_run_q <= '0;
                miss_run_q  <= '0;
              end else begin
                miss_run_q <= miss_run_q + 4'd1;
              end
            end
          end
          default: begin
            state_q  <= S_IDLE;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;

`ifdef LFSR_CHECKER_SEG_EN
  data2seg u_seg_lo (
    .data_i     (err_cnt_q[3:0]),
    .neg_show_i (1'b0),
    .seg_o      (hout[6:0])
  );

  data2seg u_seg_hi (
    .data_i     (err_cnt_q[7:4]),
    .neg_show_i (1'b0),
    .seg_o      (hout[13:7])
  );
`else
  assign hout = 14'h3FFF;
`endif
endmodule
